cpu_controller: RTL

- Multi-cycle control unit that sequences the single-cycle register-file/ALU datapath and the data memory.
- Fetches 16-bit instructions from an asynchronous-read instruction memory and decodes them. Drives every datapath control signal, the immediate value and the data-memory controls.
- Holds the program counter (PC) and instruction register (IR).
- One instruction completes every 3 cycles (FETCH, DECODE, EXEC); a taken jump takes 4 cycles.

---
 rtl/cpu_controller.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_controller.sv
// Multi-cycle control unit: fetches 16-bit instructions, holds PC/IR and
// sequences the register-file/ALU datapath and the data memory.
module cpu_controller #(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     I_data,
    output logic [PC_W-1:0] I_addr,
    output logic            I_rd,
    output logic [7:0]      D_addr,
    output logic            D_rd,
    output logic            D_wr,
    output logic [7:0]      RF_W_data,
    output logic            RF_s1,
    output logic            RF_s0,
    output logic [3:0]      RF_W_addr,
    output logic            RF_W_wr,
    output logic [3:0]      RF_Rp_addr,
    output logic            RF_Rp_rd,
    output logic [3:0]      RF_Rq_addr,
    output logic            RF_Rq_rd,
    output logic            alu_s1,
    output logic            alu_s0,
    input  logic            RF_Rp_zero,
    output logic            halted
);

    localparam logic [3:0] OP_LOAD  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_LDC   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_JZ    = 4'h5;

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_STORE,
        S_ADD,
        S_LDC,
        S_SUB,
        S_JZ,
        S_JMP,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] jmp_ofs;
    logic [15:0]     ir_q, ir_d;
    logic [3:0]      op;

    // Output values for the coming cycle, decoded from next state and next IR
    logic            i_rd_d;
    logic [7:0]      d_addr_d;
    logic            d_rd_d;
    logic            d_wr_d;
    logic [7:0]      rf_w_data_d;
    logic            rf_s1_d;
    logic            rf_s0_d;
    logic [3:0]      rf_w_addr_d;
    logic            rf_w_wr_d;
    logic [3:0]      rf_rp_addr_d;
    logic            rf_rp_rd_d;
    logic [3:0]      rf_rq_addr_d;
    logic            rf_rq_rd_d;
    logic            alu_s1_d;
    logic            alu_s0_d;
    logic            halted_d;

    assign op      = ir_q[15:12];
    // JMP runs with PC already advanced past the JZ, so the target is PC + o - 1
    assign jmp_ofs = PC_W'($signed(ir_q[7:0]));
    assign I_addr  = pc_q;

    // Next-state, PC and IR update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_INIT: begin
                pc_d    = RESET_PC;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = I_data;
                pc_d    = pc_q + PC_W'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD:  state_d = S_LOAD;
                    OP_STORE: state_d = S_STORE;
                    OP_ADD:   state_d = S_ADD;
                    OP_LDC:   state_d = S_LDC;
                    OP_SUB:   state_d = S_SUB;
                    OP_JZ:    state_d = S_JZ;
                    default:  state_d = S_HALT;
                endcase
            end
            S_LOAD, S_STORE, S_ADD, S_LDC, S_SUB: begin
                state_d = S_FETCH;
            end
            S_JZ: begin
                state_d = RF_Rp_zero ? S_JMP : S_FETCH;
            end
            S_JMP: begin
                pc_d    = pc_q + jmp_ofs - PC_W'(1);
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Moore output decode for the state being entered
    always_comb begin
        i_rd_d       = 1'b0;
        d_addr_d     = 8'h00;
        d_rd_d       = 1'b0;
        d_wr_d       = 1'b0;
        rf_w_data_d  = 8'h00;
        rf_s1_d      = 1'b0;
        rf_s0_d      = 1'b0;
        rf_w_addr_d  = 4'h0;
        rf_w_wr_d    = 1'b0;
        rf_rp_addr_d = 4'h0;
        rf_rp_rd_d   = 1'b0;
        rf_rq_addr_d = 4'h0;
        rf_rq_rd_d   = 1'b0;
        alu_s1_d     = 1'b0;
        alu_s0_d     = 1'b0;
        halted_d     = 1'b0;
        case (state_d)
            S_FETCH: begin
                i_rd_d = 1'b1;
            end
            S_LOAD: begin
                d_addr_d    = ir_d[7:0];
                d_rd_d      = 1'b1;
                rf_s1_d     = 1'b1;
                rf_w_addr_d = ir_d[11:8];
                rf_w_wr_d   = 1'b1;
            end
            S_STORE: begin
                d_addr_d     = ir_d[7:0];
                d_wr_d       = 1'b1;
                rf_rp_addr_d = ir_d[11:8];
                rf_rp_rd_d   = 1'b1;
            end
            S_ADD, S_SUB: begin
                rf_rp_addr_d = ir_d[7:4];
                rf_rp_rd_d   = 1'b1;
                rf_rq_addr_d = ir_d[3:0];
                rf_rq_rd_d   = 1'b1;
                alu_s0_d     = (state_d == S_ADD);
                alu_s1_d     = (state_d == S_SUB);
                rf_w_addr_d  = ir_d[11:8];
                rf_w_wr_d    = 1'b1;
            end
            S_LDC: begin
                rf_w_data_d = ir_d[7:0];
                rf_s0_d     = 1'b1;
                rf_w_addr_d = ir_d[11:8];
                rf_w_wr_d   = 1'b1;
            end
            S_JZ: begin
                rf_rp_addr_d = ir_d[11:8];
                rf_rp_rd_d   = 1'b1;
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, PC, IR and registered outputs; reset clears every strobe at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_INIT;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            I_rd       <= 1'b0;
            D_addr     <= 8'h00;
            D_rd       <= 1'b0;
            D_wr       <= 1'b0;
            RF_W_data  <= 8'h00;
            RF_s1      <= 1'b0;
            RF_s0      <= 1'b0;
            RF_W_addr  <= 4'h0;
            RF_W_wr    <= 1'b0;
            RF_Rp_addr <= 4'h0;
            RF_Rp_rd   <= 1'b0;
            RF_Rq_addr <= 4'h0;
            RF_Rq_rd   <= 1'b0;
            alu_s1     <= 1'b0;
            alu_s0     <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            I_rd       <= i_rd_d;
            D_addr     <= d_addr_d;
            D_rd       <= d_rd_d;
            D_wr       <= d_wr_d;
            RF_W_data  <= rf_w_data_d;
            RF_s1      <= rf_s1_d;
            RF_s0      <= rf_s0_d;
            RF_W_addr  <= rf_w_addr_d;
            RF_W_wr    <= rf_w_wr_d;
            RF_Rp_addr <= rf_rp_addr_d;
            RF_Rp_rd   <= rf_rp_rd_d;
            RF_Rq_addr <= rf_rq_addr_d;
            RF_Rq_rd   <= rf_rq_rd_d;
            alu_s1     <= alu_s1_d;
            alu_s0     <= alu_s0_d;
            halted     <= halted_d;
        end
    end

endmodule
